// File: rtl/countdown_seg_display.sv
// Two-digit seven-segment driver for the countdown timer's seconds value, with a timed alarm flash.
// Optional LEAD_ZERO_BLANK_EN blanks the tens digit when it is zero.
module countdown_seg_display #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned BLINK_HZ  = 2,
  parameter int unsigned FLASH_SEC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_sec,
  input  logic       i_timeout,
  input  logic       i_show,
  input  logic       i_clear_alarm,
  output logic [7:0] o_seg,
  output logic [1:0] o_an,
  output logic       o_alarm
);

  localparam int unsigned SCAN_DIV     = CLK_FREQ / SCAN_HZ;
  localparam int unsigned HALF_DIV     = CLK_FREQ / (2 * BLINK_HZ);
  localparam int unsigned FLASH_HALVES = 2 * BLINK_HZ * FLASH_SEC;
  localparam int unsigned SCAN_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HALF_W       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned FLASH_W      = $clog2(FLASH_HALVES + 1);

  typedef enum logic {S_IDLE, S_ALARM} state_t;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  logic [3:0]         sec_q;
  logic [SCAN_W-1:0]  scan_cnt;
  logic               digit_idx;
  state_t             state, state_nxt;
  logic [HALF_W-1:0]  blink_cnt, blink_nxt;
  logic [FLASH_W-1:0] half_cnt, half_nxt;
  logic               phase_on, phase_nxt;
  logic               tens_c;
  logic [3:0]         ones_c;
  logic               blank_c;
  logic [1:0]         an_c;
  logic [7:0]         seg_c;

  // Input sample and free-running digit scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q     <= 4'd0;
      scan_cnt  <= '0;
      digit_idx <= 1'b0;
    end else begin
      sec_q <= i_sec;
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= ~digit_idx;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end
  end

  // Alarm FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      blink_cnt <= '0;
      half_cnt  <= '0;
      phase_on  <= 1'b1;
      o_alarm   <= 1'b0;
    end else begin
      state     <= state_nxt;
      blink_cnt <= blink_nxt;
      half_cnt  <= half_nxt;
      phase_on  <= phase_nxt;
      o_alarm   <= (state_nxt == S_ALARM);
    end
  end

  // Timeout always wins over clear, so a coincident pair restarts the flash
  always_comb begin
    state_nxt = state;
    blink_nxt = blink_cnt;
    half_nxt  = half_cnt;
    phase_nxt = phase_on;
    if (i_timeout) begin
      state_nxt = S_ALARM;
      blink_nxt = '0;
      half_nxt  = '0;
      phase_nxt = 1'b1;
    end else if (state == S_ALARM) begin
      if (i_clear_alarm) begin
        state_nxt = S_IDLE;
        blink_nxt = '0;
        half_nxt  = '0;
        phase_nxt = 1'b1;
      end else if (blink_cnt == HALF_W'(HALF_DIV - 1)) begin
        blink_nxt = '0;
        phase_nxt = ~phase_on;
        half_nxt  = half_cnt + FLASH_W'(1);
        if (half_cnt == FLASH_W'(FLASH_HALVES - 1)) begin
          state_nxt = S_IDLE;
          half_nxt  = '0;
          phase_nxt = 1'b1;
        end
      end else begin
        blink_nxt = blink_cnt + HALF_W'(1);
      end
    end
  end

  // Digit split, blanking and segment selection
  always_comb begin
    tens_c  = (sec_q >= 4'd10);
    ones_c  = tens_c ? (sec_q - 4'd10) : sec_q;
    blank_c = (state == S_ALARM) && !phase_on;
    an_c    = 2'b00;
    seg_c   = 8'h00;
    if (i_show && !blank_c) begin
      if (!digit_idx) begin
        an_c  = 2'b01;
        seg_c = seg_enc(ones_c);
      end else begin
`ifdef LEAD_ZERO_BLANK_EN
        if (tens_c) begin
          an_c  = 2'b10;
          seg_c = seg_enc({3'b000, tens_c});
        end
`else
        an_c  = 2'b10;
        seg_c = seg_enc({3'b000, tens_c});
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_an  <= 2'b00;
      o_seg <= 8'h00;
    end else begin
      o_an  <= an_c;
      o_seg <= seg_c;
    end
  end

endmodule
